// File: rtl/regfile_alu_pipe.sv
// DEPTH x DATA_W register file feeding a 2-stage ALU pipe with valid/ready handshakes.
// Define REGALU_SAT_EN to saturate ADD/SUB results on signed overflow instead of wrapping.
module regfile_alu_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data_in,
  input  logic              oen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ovf
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_READ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;
  localparam int unsigned MSB = DATA_W - 1;
`ifdef REGALU_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic [DATA_W-1:0] r_rf [DEPTH];

  logic              r_s1_valid;
  logic [2:0]        r_s1_op;
  logic [ADDR_W-1:0] r_s1_d;
  logic [DATA_W-1:0] r_s1_data;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_ovf;

  logic              w_adv;
  logic              w_s1_wr;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_dif;
  logic [DATA_W-1:0] w_res;
  logic              w_ovf;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = rst_n & w_adv;

  // Out-of-range addresses never match a row, so reads fall through to zero.
  always_comb begin
    w_rf_a = '0;
    w_rf_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ADDR_W'(i) == addr_a) w_rf_a = r_rf[i];
      if (ADDR_W'(i) == addr_b) w_rf_b = r_rf[i];
    end
  end

  assign w_s1_wr = r_s1_valid && (r_s1_op <= OP_XOR) && (32'(r_s1_d) < DEPTH);

  // S1 writes back on the same edge the next instruction issues, so bypass the RF.
  assign w_opa = (w_s1_wr && (r_s1_d == addr_a)) ? w_res : w_rf_a;
  assign w_opb = (w_s1_wr && (r_s1_d == addr_b)) ? w_res : w_rf_b;

  always_comb begin
    w_sum = r_s1_a + r_s1_b;
    w_dif = r_s1_a - r_s1_b;
    w_res = '0;
    w_ovf = 1'b0;
    case (r_s1_op)
      OP_LOAD: w_res = r_s1_data;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_dif[MSB] != r_s1_a[MSB]);
      end
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_READ: w_res = r_s1_a;
      default: w_res = '0;
    endcase
`ifdef REGALU_SAT_EN
    if (w_ovf) w_res = r_s1_a[MSB] ? SAT_MIN : SAT_MAX;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OP_NOP;
      r_s1_d      <= '0;
      r_s1_data   <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_op     <= op;
      r_s1_d      <= addr_d;
      r_s1_data   <= data_in;
      r_s1_a      <= w_opa;
      r_s1_b      <= w_opb;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_res;
        r_ovf      <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_rf[i] <= '0;
    end else if (w_adv && w_s1_wr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ADDR_W'(i) == r_s1_d) r_rf[i] <= w_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = oen ? r_out_data : '0;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: a sequential reference model fills a scoreboard
// at acceptance time and a monitor pops it on every output transfer.
module tb_regfile_alu_pipe;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;
  localparam int IW  = 4;

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, SUB = 3'b010, ANDO = 3'b011;
  localparam logic [2:0] ORO = 3'b100, XORO = 3'b101, READ = 3'b110, NOP = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [AW-1:0] addr_a, addr_b, addr_d;
  logic [DW-1:0] data_in;
  logic          oen;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ovf;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          o;
  } exp_t;

  exp_t          q_exp[$];
  logic [DW-1:0] m_rf [DEP];
  int            n_tests = 0;
  int            n_fail  = 0;

  regfile_alu_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .addr_d   (addr_d),
    .data_in  (data_in),
    .oen      (oen),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (int'(a) < DEP) ? m_rf[a[IW-1:0]] : '0;
  endfunction

  // Independent reference: overflow judged against the exact signed result.
  function automatic exp_t model(input logic [2:0] o, input logic [AW-1:0] a,
                                 input logic [AW-1:0] b, input logic [DW-1:0] di);
    exp_t          e;
    logic [DW-1:0] va, vb;
    longint        s, maxs, mins;
    va   = rd(a);
    vb   = rd(b);
    s    = 0;
    maxs = (longint'(1) <<< (DW - 1)) - 1;
    mins = -(longint'(1) <<< (DW - 1));
    e.d  = '0;
    e.o  = 1'b0;
    case (o)
      LOAD: e.d = di;
      ADD: begin
        s   = longint'($signed(va)) + longint'($signed(vb));
        e.d = va + vb;
        e.o = (s > maxs) || (s < mins);
      end
      SUB: begin
        s   = longint'($signed(va)) - longint'($signed(vb));
        e.d = va - vb;
        e.o = (s > maxs) || (s < mins);
      end
      ANDO: e.d = va & vb;
      ORO:  e.d = va | vb;
      XORO: e.d = va ^ vb;
      READ: e.d = va;
      default: e.d = '0;
    endcase
`ifdef REGALU_SAT_EN
    if (e.o) e.d = (s < 0) ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [DW-1:0] di);
    bit   acc;
    int   guard;
    exp_t e;
    acc      = 1'b0;
    guard    = 0;
    op       = o;
    addr_a   = a;
    addr_b   = b;
    addr_d   = d;
    data_in  = di;
    in_valid = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      guard++;
    end
    if (!acc) begin
      chk("issue_timeout", 32'(in_ready), 32'(1));
    end else begin
      e = model(o, a, b, di);
      q_exp.push_back(e);
      if (o <= XORO && int'(d) < DEP) m_rf[d[IW-1:0]] = e.d;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q_exp.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 32'(q_exp.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        chk("extra_beat", out_data, 'x);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    int            guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = NOP;
    addr_a    = '0;
    addr_b    = '0;
    addr_d    = '0;
    data_in   = '0;
    oen       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < DEP; i++) m_rf[i] = '0;

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Wrap to zero, then READ of the written register.
    issue(LOAD, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFEF);
    issue(LOAD, 5'd0, 5'd0, 5'd1, 32'h0000_0011);
    issue(ADD,  5'd0, 5'd1, 5'd3, 32'h0);
    issue(READ, 5'd3, 5'd0, 5'd9, 32'h0);

    // Back-to-back forwarding chain.
    issue(LOAD, 5'd0, 5'd0, 5'd2, 32'h0000_0022);
    issue(ADD,  5'd2, 5'd2, 5'd4, 32'h0);
    issue(XORO, 5'd4, 5'd2, 5'd5, 32'h0);

    // Signed overflow corners.
    issue(LOAD, 5'd0, 5'd0, 5'd6, 32'h7FFF_FFFF);
    issue(LOAD, 5'd0, 5'd0, 5'd7, 32'h0000_0001);
    issue(ADD,  5'd6, 5'd7, 5'd8, 32'h0);
    issue(LOAD, 5'd0, 5'd0, 5'd9, 32'h8000_0000);
    issue(SUB,  5'd9, 5'd7, 5'd10, 32'h0);
    issue(SUB,  5'd15, 5'd9, 5'd11, 32'h0);
    issue(ANDO, 5'd0, 5'd1, 5'd12, 32'h0);
    issue(ORO,  5'd0, 5'd2, 5'd13, 32'h0);
    issue(NOP,  5'd6, 5'd7, 5'd1, 32'h1234);
    issue(READ, 5'd1, 5'd0, 5'd0, 32'h0);

    // Out-of-range writes dropped, reads zero, no bypass from a dropped write.
    issue(LOAD, 5'd0, 5'd0, 5'd20, 32'h0000_005A);
    issue(ADD,  5'd20, 5'd20, 5'd14, 32'h0);
    issue(READ, 5'd20, 5'd0, 5'd0, 32'h0);
    issue(LOAD, 5'd0, 5'd0, 5'd31, 32'hDEAD_BEEF);
    issue(READ, 5'd31, 5'd0, 5'd0, 32'h0);
    drain();

    // Backpressure: four instructions, consumer stalls for three cycles.
    out_ready = 1'b0;
    fork
      begin
        issue(LOAD, 5'd0, 5'd0, 5'd3, 32'h0000_00A1);
        issue(LOAD, 5'd0, 5'd0, 5'd4, 32'h0000_00B2);
        issue(ADD,  5'd3, 5'd4, 5'd5, 32'h0);
        issue(READ, 5'd5, 5'd0, 5'd0, 32'h0);
      end
      begin
        repeat (3) @(negedge clk);
        held = out_data;
        chk("stall_out_valid", 32'(out_valid), 32'(1));
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        chk("stall_first_beat", held, 32'h0000_00A1);
        @(negedge clk);
        chk("stall_hold_data", out_data, held);
        chk("stall_in_ready2", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Output enable gating on a held ADD beat of 0x22.
    out_ready = 1'b0;
    issue(ADD, 5'd2, 5'd15, 5'd14, 32'h0);
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("oen_beat_valid", 32'(out_valid), 32'(1));
    oen = 1'b0;
    #1 chk("oen_low", out_data, 32'h0);
    oen = 1'b1;
    #1 chk("oen_high", out_data, 32'h0000_0022);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Asynchronous reset with two instructions in flight.
    issue(LOAD, 5'd0, 5'd0, 5'd1, 32'h0000_0055);
    issue(LOAD, 5'd0, 5'd0, 5'd2, 32'h0000_0066);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
    chk("mid_rst_out_data", out_data, 32'h0);
    q_exp.delete();
    for (int i = 0; i < DEP; i++) m_rf[i] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_no_beat", 32'(out_valid), 32'(0));
    issue(READ, 5'd0, 5'd0, 5'd0, 32'h0);
    issue(READ, 5'd6, 5'd0, 5'd0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
